ibex_fp_issue_ctrl: RTL and testbench

Issue and writeback controller on the core side of the `ibex_FPU` port set. It accepts one decoded FP request at a time over a valid/ready handshake and reads operands from its own FP register file. It drives `fp_op`, operands and `rd_addr` to the FPU for exactly one cycle, then holds `FPU_NOP`. It captures the FPU's FP or integer write strobes, updates the FP register file, and forwards integer results to the integer pipeline.

---
 rtl/ibex_fp_pkg.sv | 23 ++
 rtl/ibex_fp_regfile.sv | 51 +++++
 rtl/ibex_fp_issue_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ibex_fp_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_fp_pkg.sv
// rtl/ibex_fp_pkg.sv - shared FPU operation and issue-controller state types
package ibex_fp_pkg;

    typedef enum logic [3:0] {
        FPU_NOP       = 4'd0,
        FPU_ADD       = 4'd1,
        FPU_SUB       = 4'd2,
        FPU_MUL       = 4'd3,
        FPU_DIV       = 4'd4,
        FPU_SQRT      = 4'd5,
        FPU_FMADD     = 4'd6,
        FPU_FLOAT2INT = 4'd7,
        FPU_INT2FLOAT = 4'd8
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        COOL  = 2'd3
    } fp_issue_state_e;

endpackage

// File: rtl/ibex_fp_regfile.sv
// rtl/ibex_fp_regfile.sv - FP register file, three operand reads, debug read, muxed write port
module ibex_fp_regfile
    import ibex_fp_pkg::*;
#(
    parameter int unsigned NUM_FP_REGS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    input  logic [4:0]  raddr3_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    output logic [31:0] rdata3_o,
    input  logic [4:0]  dbg_raddr_i,
    output logic [31:0] dbg_rdata_o,
    input  logic        fpu_we_i,
    input  logic [4:0]  fpu_waddr_i,
    input  logic [31:0] fpu_wdata_i,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_waddr_i,
    input  logic [31:0] dbg_wdata_i
);

    logic [31:0] regs_q [NUM_FP_REGS];
    logic [31:0] regs_d [NUM_FP_REGS];

    // FPU and debug writes are never enabled together: one is gated to IDLE, the other excluded from it
    always_comb begin
        regs_d = regs_q;
        if (fpu_we_i) begin
            regs_d[fpu_waddr_i] = fpu_wdata_i;
        end else if (dbg_we_i) begin
            regs_d[dbg_waddr_i] = dbg_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1_o    = regs_q[raddr1_i];
    assign rdata2_o    = regs_q[raddr2_i];
    assign rdata3_o    = regs_q[raddr3_i];
    assign dbg_rdata_o = regs_q[dbg_raddr_i];

endmodule

// File: rtl/ibex_fp_issue_ctrl.sv
// rtl/ibex_fp_issue_ctrl.sv - single-outstanding FP issue and writeback controller
module ibex_fp_issue_ctrl
    import ibex_fp_pkg::*;
#(
    parameter int unsigned NUM_FP_REGS    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  fpu_op_e     req_op_i,
    input  logic [2:0]  req_rm_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [4:0]  req_rs3_i,
    input  logic [4:0]  req_rd_i,
    input  logic [31:0] req_int_operand_i,
    output fpu_op_e     fp_op_o,
    output logic [2:0]  fp_rounding_mode_o,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o,
    output logic [31:0] rs3_o,
    output logic [31:0] rs1_int_o,
    output logic [4:0]  rd_addr_o,
    input  logic        fp_regfile_write_i,
    input  logic [4:0]  fp_regfile_addr_i,
    input  logic [31:0] fp_regfile_wdata_i,
    input  logic        int_regfile_write_i,
    input  logic [4:0]  int_regfile_addr_i,
    input  logic [31:0] int_regfile_wdata_i,
    output logic        int_wb_valid_o,
    output logic [4:0]  int_wb_addr_o,
    output logic [31:0] int_wb_data_o,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic [31:0] dbg_rdata_o,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    fp_issue_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fpu_op_e     op_q, op_d;
    logic [2:0]  rm_q, rm_d;
    logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d, rs1_int_q, rs1_int_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        timeout_q, timeout_d;

    logic [31:0] rf_rs1, rf_rs2, rf_rs3;
    logic        in_idle, honor, fp_we, int_we, dbg_we;

    assign in_idle = (state_q == IDLE);
    // Strobes count only while an operation is outstanding; leaving ISSUE/WAIT drops any repeats
    assign honor   = (state_q == ISSUE) || (state_q == WAIT);
    assign fp_we   = honor && fp_regfile_write_i;
    assign int_we  = honor && int_regfile_write_i;
    assign dbg_we  = in_idle && dbg_we_i;

    ibex_fp_regfile #(
        .NUM_FP_REGS (NUM_FP_REGS)
    ) u_regfile (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .raddr1_i    (req_rs1_i),
        .raddr2_i    (req_rs2_i),
        .raddr3_i    (req_rs3_i),
        .rdata1_o    (rf_rs1),
        .rdata2_o    (rf_rs2),
        .rdata3_o    (rf_rs3),
        .dbg_raddr_i (dbg_addr_i),
        .dbg_rdata_o (dbg_rdata_o),
        .fpu_we_i    (fp_we),
        .fpu_waddr_i (fp_regfile_addr_i),
        .fpu_wdata_i (fp_regfile_wdata_i),
        .dbg_we_i    (dbg_we),
        .dbg_waddr_i (dbg_addr_i),
        .dbg_wdata_i (dbg_wdata_i)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rm_d       = rm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs3_d      = rs3_q;
        rs1_int_d  = rs1_int_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        timeout_d  = timeout_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d      = req_op_i;
                    rm_d      = req_rm_i;
                    rs1_d     = rf_rs1;
                    rs2_d     = rf_rs2;
                    rs3_d     = rf_rs3;
                    rs1_int_d = req_int_operand_i;
                    rd_d      = req_rd_i;
                    if (req_op_i != FPU_NOP) begin
                        state_d = ISSUE;
                        cnt_d   = '0;
                    end
                end
            end
            ISSUE: begin
                state_d = (fp_we || int_we) ? COOL : WAIT;
            end
            WAIT: begin
                if (fp_we || int_we) begin
                    state_d = COOL;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COOL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (int_we) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = int_regfile_addr_i;
            wb_data_d  = int_regfile_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= FPU_NOP;
            rm_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs3_q      <= '0;
            rs1_int_q  <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            rm_q       <= rm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs3_q      <= rs3_d;
            rs1_int_q  <= rs1_int_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            timeout_q  <= timeout_d;
        end
    end

    assign req_ready_o        = in_idle;
    assign busy_o             = !in_idle;
    assign fp_op_o            = (state_q == ISSUE) ? op_q : FPU_NOP;
    assign fp_rounding_mode_o = rm_q;
    assign rs1_o              = rs1_q;
    assign rs2_o              = rs2_q;
    assign rs3_o              = rs3_q;
    assign rs1_int_o          = rs1_int_q;
    assign rd_addr_o          = rd_q;
    assign int_wb_valid_o     = wb_valid_q;
    assign int_wb_addr_o      = wb_addr_q;
    assign int_wb_data_o      = wb_data_q;
    assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_ibex_fp_issue_ctrl.sv
// tb/tb_ibex_fp_issue_ctrl.sv - directed plus randomized bench for ibex_fp_issue_ctrl
module tb_ibex_fp_issue_ctrl;
    import ibex_fp_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    fpu_op_e     req_op_i = FPU_NOP;
    logic [2:0]  req_rm_i = '0;
    logic [4:0]  req_rs1_i = '0, req_rs2_i = '0, req_rs3_i = '0, req_rd_i = '0;
    logic [31:0] req_int_operand_i = '0;
    fpu_op_e     fp_op_o;
    logic [2:0]  fp_rounding_mode_o;
    logic [31:0] rs1_o, rs2_o, rs3_o, rs1_int_o;
    logic [4:0]  rd_addr_o;
    logic        fp_regfile_write_i = 1'b0;
    logic [4:0]  fp_regfile_addr_i = '0;
    logic [31:0] fp_regfile_wdata_i = '0;
    logic        int_regfile_write_i = 1'b0;
    logic [4:0]  int_regfile_addr_i = '0;
    logic [31:0] int_regfile_wdata_i = '0;
    logic        int_wb_valid_o;
    logic [4:0]  int_wb_addr_o;
    logic [31:0] int_wb_data_o;
    logic        dbg_we_i = 1'b0;
    logic [4:0]  dbg_addr_i = '0;
    logic [31:0] dbg_wdata_i = '0;
    logic [31:0] dbg_rdata_o;
    logic        busy_o, timeout_o;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] m_regs [32];
    logic        m_timeout;
    logic [4:0]  m_wb_addr;
    logic [31:0] m_wb_data;

    always #5 clk = ~clk;

    ibex_fp_issue_ctrl #(.NUM_FP_REGS(32), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_rm_i(req_rm_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .req_rs3_i(req_rs3_i), .req_rd_i(req_rd_i), .req_int_operand_i(req_int_operand_i),
        .fp_op_o(fp_op_o), .fp_rounding_mode_o(fp_rounding_mode_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rs3_o(rs3_o), .rs1_int_o(rs1_int_o), .rd_addr_o(rd_addr_o),
        .fp_regfile_write_i(fp_regfile_write_i), .fp_regfile_addr_i(fp_regfile_addr_i),
        .fp_regfile_wdata_i(fp_regfile_wdata_i),
        .int_regfile_write_i(int_regfile_write_i), .int_regfile_addr_i(int_regfile_addr_i),
        .int_regfile_wdata_i(int_regfile_wdata_i),
        .int_wb_valid_o(int_wb_valid_o), .int_wb_addr_o(int_wb_addr_o), .int_wb_data_o(int_wb_data_o),
        .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_rdata_o(dbg_rdata_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_timeout = 1'b0;
        m_wb_addr = '0;
        m_wb_data = '0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_addr_i = 5'(i);
            #1;
            chk(tag, dbg_rdata_o, m_regs[i]);
        end
        next_cyc();
    endtask

    task automatic check_reset_outputs();
        chk("rst_fp_op", 32'(fp_op_o), 32'(FPU_NOP));
        chk("rst_ready", 32'(req_ready_o), 1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        chk("rst_rm", 32'(fp_rounding_mode_o), 0);
        chk("rst_rs1", rs1_o, 0);
        chk("rst_rs2", rs2_o, 0);
        chk("rst_rs3", rs3_o, 0);
        chk("rst_rs1_int", rs1_int_o, 0);
        chk("rst_rd", 32'(rd_addr_o), 0);
        chk("rst_wb_valid", 32'(int_wb_valid_o), 0);
        chk("rst_wb_addr", 32'(int_wb_addr_o), 0);
        chk("rst_wb_data", int_wb_data_o, 0);
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        dbg_we_i = 1'b1; dbg_addr_i = a; dbg_wdata_i = d;
        next_cyc();
        dbg_we_i = 1'b0;
        m_regs[a] = d;
    endtask

    // One complete operation. k: cycle (0 = ISSUE) in which the FPU answers; kind bit0 = FP strobe, bit1 = int strobe.
    task automatic do_op(input fpu_op_e op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] r3, input logic [4:0] rd, input logic [2:0] rm,
                         input logic [31:0] iop, input int k, input int kind,
                         input logic [4:0] fa, input logic [31:0] fd,
                         input logic [4:0] ia, input logic [31:0] id,
                         input bit dbg_acc, input logic [4:0] da, input logic [31:0] dd);
        logic [31:0] e1, e2, e3;
        int busy_n, op_n, wb_n, exp_busy;
        bit resp;
        e1 = m_regs[r1]; e2 = m_regs[r2]; e3 = m_regs[r3];
        // The controller gives up T+2 cycles after accept; any answer before that is taken
        resp = (k <= T + 1);
        exp_busy = resp ? k + 2 : T + 2;
        chk("ready_before_accept", 32'(req_ready_o), 1);
        req_valid_i = 1'b1; req_op_i = op; req_rm_i = rm; req_int_operand_i = iop;
        req_rs1_i = r1; req_rs2_i = r2; req_rs3_i = r3; req_rd_i = rd;
        if (dbg_acc) begin
            dbg_we_i = 1'b1; dbg_addr_i = da; dbg_wdata_i = dd;
        end
        next_cyc();
        req_valid_i = 1'b0; dbg_we_i = 1'b0;
        if (dbg_acc) m_regs[da] = dd;
        chk("issue_fp_op", 32'(fp_op_o), 32'(op));
        chk("issue_rs1", rs1_o, e1);
        chk("issue_rs2", rs2_o, e2);
        chk("issue_rs3", rs3_o, e3);
        chk("issue_rs1_int", rs1_int_o, iop);
        chk("issue_rd", 32'(rd_addr_o), 32'(rd));
        chk("issue_rm", 32'(fp_rounding_mode_o), 32'(rm));
        busy_n = 0; op_n = 0; wb_n = 0;
        for (int c = 0; c < 200 && busy_o; c++) begin
            busy_n++;
            if (fp_op_o != FPU_NOP) op_n++;
            if (int_wb_valid_o) begin
                wb_n++;
                chk("wb_addr", 32'(int_wb_addr_o), 32'(ia));
                chk("wb_data", int_wb_data_o, id);
            end
            fp_regfile_write_i = 1'b0; int_regfile_write_i = 1'b0;
            if (c == k) begin
                fp_regfile_write_i = kind[0]; fp_regfile_addr_i = fa; fp_regfile_wdata_i = fd;
                int_regfile_write_i = kind[1]; int_regfile_addr_i = ia; int_regfile_wdata_i = id;
            end else if (c == k + 1) begin
                fp_regfile_write_i = 1'b1; fp_regfile_addr_i = fa ^ 5'd1; fp_regfile_wdata_i = ~fd;
                int_regfile_write_i = 1'b1; int_regfile_addr_i = ~ia; int_regfile_wdata_i = ~id;
            end
            if (c == 0) begin
                dbg_we_i = 1'b1; dbg_addr_i = 5'($urandom_range(0, 31)); dbg_wdata_i = $urandom;
            end
            next_cyc();
            fp_regfile_write_i = 1'b0; int_regfile_write_i = 1'b0; dbg_we_i = 1'b0;
        end
        if (resp && kind[0] != 0) m_regs[fa] = fd;
        if (resp && kind[1] != 0) begin
            m_wb_addr = ia; m_wb_data = id;
        end
        if (!resp) m_timeout = 1'b1;
        chk("ready_returns", 32'(busy_o), 0);
        chk("ready_after", 32'(req_ready_o), 1);
        chk("busy_cycles", busy_n, exp_busy);
        chk("fp_op_cycles", op_n, 1);
        chk("wb_pulses", wb_n, (resp && kind[1] != 0) ? 1 : 0);
        chk("wb_valid_idle", 32'(int_wb_valid_o), 0);
        chk("fp_op_idle", 32'(fp_op_o), 32'(FPU_NOP));
        chk("wb_addr_hold", 32'(int_wb_addr_o), 32'(m_wb_addr));
        chk("wb_data_hold", int_wb_data_o, m_wb_data);
        chk("timeout_flag", 32'(timeout_o), 32'(m_timeout));
        chk("rs1_hold", rs1_o, e1);
    endtask

    initial begin
        model_reset();
        next_cyc();
        next_cyc();
        rst_i = 1'b0;
        check_reset_outputs();
        check_regs("rst_regs");

        preload(5'd1, 32'h4023d70a);
        preload(5'd2, 32'h41200000);
        do_op(FPU_ADD, 5'd2, 5'd1, 5'd0, 5'd3, 3'd0, 32'h0, 0, 1,
              5'd3, 32'h41490a3d, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_regs("add_regs");

        do_op(FPU_FLOAT2INT, 5'd3, 5'd0, 5'd0, 5'd15, 3'd1, 32'h0, 0, 2,
              5'd0, 32'h0, 5'd15, 32'd12, 1'b0, 5'd0, 32'h0);
        check_regs("f2i_regs");

        do_op(FPU_MUL, 5'd1, 5'd2, 5'd3, 5'd6, 3'd2, 32'h0, 5, 1,
              5'd6, 32'h42c80000, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_regs("delay5_regs");

        do_op(FPU_DIV, 5'd1, 5'd2, 5'd3, 5'd7, 3'd3, 32'h0, 99, 3,
              5'd7, 32'h11111111, 5'd9, 32'h2222, 1'b0, 5'd0, 32'h0);
        check_regs("timeout_regs");

        do_op(FPU_FMADD, 5'd6, 5'd3, 5'd1, 5'd0, 3'd4, 32'h55, 2, 3,
              5'd0, 32'hcafef00d, 5'd21, 32'h0bad0bad, 1'b1, 5'd6, 32'h12345678);
        check_regs("both_dbgacc_regs");

        // Reset while waiting, then late strobes must be ignored
        req_valid_i = 1'b1; req_op_i = FPU_SQRT; req_rs1_i = 5'd6; req_rd_i = 5'd4;
        next_cyc();
        req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) next_cyc();
        chk("busy_in_wait", 32'(busy_o), 1);
        rst_i = 1'b1;
        next_cyc();
        rst_i = 1'b0;
        model_reset();
        fp_regfile_write_i = 1'b1; fp_regfile_addr_i = 5'd4; fp_regfile_wdata_i = 32'hdeadbeef;
        int_regfile_write_i = 1'b1; int_regfile_addr_i = 5'd4; int_regfile_wdata_i = 32'hdeadbeef;
        next_cyc();
        next_cyc();
        fp_regfile_write_i = 1'b0; int_regfile_write_i = 1'b0;
        check_reset_outputs();
        check_regs("post_rst_regs");

        chk("nop_ready", 32'(req_ready_o), 1);
        req_valid_i = 1'b1; req_op_i = FPU_NOP; req_rs1_i = 5'd1;
        next_cyc();
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("nop_busy", 32'(busy_o), 0);
            chk("nop_fp_op", 32'(fp_op_o), 32'(FPU_NOP));
            next_cyc();
        end

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) preload(5'($urandom_range(0, 31)), $urandom);
            do_op(fpu_op_e'(4'($urandom_range(1, 8))),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), $urandom,
                  int'($urandom_range(0, 12)), int'($urandom_range(1, 3)),
                  5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
        check_regs("rand_regs");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
